// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response and data-memory bus bundle for load_store_unit.
// master: the LSU view (takes pipeline requests, initiates memory accesses).
// slave:  the environment view (pipeline plus data memory).
interface load_store_unit_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        func3;
  logic [31:0]       wdata;
  logic              resp_valid;
  logic [31:0]       rdata;
  logic              misalign_err;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [3:0]        m_be;
  logic [31:0]       m_wdata;
  logic              m_ack;
  logic [31:0]       m_rdata;

  modport master (
    input  req_valid, mem_read, mem_write, addr, func3, wdata, m_ack, m_rdata,
    output req_ready, resp_valid, rdata, misalign_err, m_req, m_we, m_addr, m_be, m_wdata
  );

  modport slave (
    output req_valid, mem_read, mem_write, addr, func3, wdata, m_ack, m_rdata,
    input  req_ready, resp_valid, rdata, misalign_err, m_req, m_we, m_addr, m_be, m_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: RV32 func3 size/sign decoding, byte-lane strobes,
// misaligned accesses split into two word accesses (address wraps mod 2^ADDR_W).
// Optional feature macro MISALIGN_TRAP_EN: misaligned H/HU/W accesses are not
// issued and complete with misalign_err=1 instead of being split.
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  load_store_unit_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            state_r, next_s;
  logic              we_r;
  logic [2:0]        func3_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       lo_r;

  logic              req_ready_r, resp_valid_r, misalign_err_r;
  logic [31:0]       rdata_r;
  logic              m_req_r, m_we_r;
  logic [ADDR_W-1:0] m_addr_r;
  logic [3:0]        m_be_r;
  logic [31:0]       m_wdata_r;

  logic              req_ready_s, resp_valid_s, misalign_err_s;
  logic [31:0]       rdata_s;
  logic              m_req_s, m_we_s;
  logic [ADDR_W-1:0] m_addr_s;
  logic [3:0]        m_be_s;
  logic [31:0]       m_wdata_s;

  // Byte-lane mask for the access size, before shifting by the byte offset.
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Unsigned variants only exist for loads; 011/110/111 are never valid.
  function automatic logic is_illegal(input logic [2:0] f3, input logic we);
    case (f3)
      3'b000, 3'b001, 3'b010: return 1'b0;
      3'b100, 3'b101:         return we;
      default:                return 1'b1;
    endcase
  endfunction

  // Sign/zero extension of the offset-aligned load word.
  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] s);
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h000000, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0000, s[15:0]};
      3'b010:  return s;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // While IDLE the incoming request is decoded directly so the first access
  // can be registered on the accepting edge; afterwards the latched copy is used.
  logic              in_idle_s, accept_s;
  logic              src_we_s;
  logic [2:0]        src_func3_s;
  logic [ADDR_W-1:0] src_addr_s;
  logic [31:0]       src_wdata_s;
  logic [7:0]        be8_s;
  logic [63:0]       d64_s;
  logic              split_s, illegal_s, trap_s;
  logic [ADDR_W-1:0] word0_s, word1_s;
  logic [63:0]       load_words_s;
  logic [31:0]       load_s;

  assign in_idle_s   = (state_r == IDLE);
  assign accept_s    = in_idle_s & bus.req_valid & req_ready_r & (bus.mem_read | bus.mem_write);
  assign src_we_s    = in_idle_s ? bus.mem_write : we_r;
  assign src_func3_s = in_idle_s ? bus.func3     : func3_r;
  assign src_addr_s  = in_idle_s ? bus.addr      : addr_r;
  assign src_wdata_s = in_idle_s ? bus.wdata     : wdata_r;

  assign be8_s     = {4'b0000, size_mask(src_func3_s)} << src_addr_s[1:0];
  assign d64_s     = {32'h0000_0000, src_wdata_s} << {src_addr_s[1:0], 3'b000};
  assign split_s   = |be8_s[7:4];
  assign illegal_s = is_illegal(src_func3_s, src_we_s);
  assign word0_s   = {src_addr_s[ADDR_W-1:2], 2'b00};
  assign word1_s   = word0_s + ADDR_W'(4);

`ifdef MISALIGN_TRAP_EN
  assign trap_s = ~illegal_s & (((src_func3_s[1:0] == 2'b01) & src_addr_s[0]) |
                                ((src_func3_s[1:0] == 2'b10) & (src_addr_s[1:0] != 2'b00)));
`else
  assign trap_s = 1'b0;
`endif

  // A non-split load only ever needs bytes of the first word.
  assign load_words_s = (state_r == ACC1) ? {bus.m_rdata, lo_r} : {32'h0000_0000, bus.m_rdata};
  assign load_s       = 32'(load_words_s >> {addr_r[1:0], 3'b000});

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; m_ack only matters while an access is outstanding.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) next_s = (illegal_s | trap_s) ? RESP : ACC0; else next_s = IDLE;
      ACC0:    if (bus.m_ack) next_s = split_s ? ACC1 : RESP; else next_s = ACC0;
      ACC1:    if (bus.m_ack) next_s = RESP; else next_s = ACC1;
      RESP:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the state being entered.
  always_comb begin
    req_ready_s    = (next_s == IDLE);
    resp_valid_s   = (next_s == RESP);
    rdata_s        = 32'h0000_0000;
    misalign_err_s = 1'b0;
    m_req_s        = 1'b0;
    m_we_s         = 1'b0;
    m_addr_s       = '0;
    m_be_s         = 4'b0000;
    m_wdata_s      = 32'h0000_0000;
    case (next_s)
      ACC0: begin
        m_req_s   = 1'b1;
        m_we_s    = src_we_s;
        m_addr_s  = word0_s;
        m_be_s    = be8_s[3:0];
        m_wdata_s = d64_s[31:0];
      end
      ACC1: begin
        m_req_s   = 1'b1;
        m_we_s    = src_we_s;
        m_addr_s  = word1_s;
        m_be_s    = be8_s[7:4];
        m_wdata_s = d64_s[63:32];
      end
      RESP: begin
        if (!in_idle_s && !we_r) begin
          rdata_s = extend_load(func3_r, load_s);
        end else begin
          rdata_s = 32'h0000_0000;
        end
        misalign_err_s = in_idle_s & trap_s;
      end
      default: begin
        m_req_s = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_ready_r    <= 1'b1;
      resp_valid_r   <= 1'b0;
      rdata_r        <= 32'h0000_0000;
      misalign_err_r <= 1'b0;
      m_req_r        <= 1'b0;
      m_we_r         <= 1'b0;
      m_addr_r       <= '0;
      m_be_r         <= 4'b0000;
      m_wdata_r      <= 32'h0000_0000;
    end else begin
      req_ready_r    <= req_ready_s;
      resp_valid_r   <= resp_valid_s;
      rdata_r        <= rdata_s;
      misalign_err_r <= misalign_err_s;
      m_req_r        <= m_req_s;
      m_we_r         <= m_we_s;
      m_addr_r       <= m_addr_s;
      m_be_r         <= m_be_s;
      m_wdata_r      <= m_wdata_s;
    end
  end

  // Request capture on accept, and low-word capture on the first load ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      func3_r <= 3'b000;
      addr_r  <= '0;
      wdata_r <= 32'h0000_0000;
      lo_r    <= 32'h0000_0000;
    end else begin
      if (accept_s) begin
        we_r    <= bus.mem_write;
        func3_r <= bus.func3;
        addr_r  <= bus.addr;
        wdata_r <= bus.wdata;
      end else begin
        we_r    <= we_r;
        func3_r <= func3_r;
        addr_r  <= addr_r;
        wdata_r <= wdata_r;
      end
      lo_r <= ((state_r == ACC0) && bus.m_ack) ? bus.m_rdata : lo_r;
    end
  end

  assign bus.req_ready    = req_ready_r;
  assign bus.resp_valid   = resp_valid_r;
  assign bus.rdata        = rdata_r;
  assign bus.misalign_err = misalign_err_r;
  assign bus.m_req        = m_req_r;
  assign bus.m_we         = m_we_r;
  assign bus.m_addr       = m_addr_r;
  assign bus.m_be         = m_be_r;
  assign bus.m_wdata      = m_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit; builds with or without MISALIGN_TRAP_EN.
module tb_load_store_unit;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  load_store_unit_if #(.ADDR_W(10)) bus ();

  load_store_unit #(.ADDR_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Present one request at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic rd, input logic wr, input logic [9:0] a,
                       input logic [2:0] f3, input logic [31:0] wd);
    bus.req_valid = 1'b1;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.addr      = a;
    bus.func3     = f3;
    bus.wdata     = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_acc(input string tag, input logic we, input logic [9:0] a,
                           input logic [3:0] be, input logic [31:0] wd);
    check({tag, "_req"},   {31'd0, bus.m_req},     32'd1);
    check({tag, "_we"},    {31'd0, bus.m_we},      {31'd0, we});
    check({tag, "_addr"},  {22'd0, bus.m_addr},    {22'd0, a});
    check({tag, "_be"},    {28'd0, bus.m_be},      {28'd0, be});
    check({tag, "_wdata"}, bus.m_wdata,            wd);
    check({tag, "_rdy"},   {31'd0, bus.req_ready}, 32'd0);
  endtask

  // Check one memory access, optionally stall, then acknowledge it.
  task automatic serve(input string tag, input logic we, input logic [9:0] a,
                       input logic [3:0] be, input logic [31:0] wd,
                       input logic [31:0] rd, input int stall);
    check_acc(tag, we, a, be, wd);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_acc({tag, "_stall"}, we, a, be, wd);
    end
    bus.m_ack   = 1'b1;
    bus.m_rdata = rd;
    @(posedge clk);
    #1;
    bus.m_ack   = 1'b0;
    bus.m_rdata = 32'h0000_0000;
    @(negedge clk);
  endtask

  // Expect the completion pulse now, and its absence one cycle later.
  task automatic resp(input string tag, input logic [31:0] rd, input logic err);
    check({tag, "_rv"},   {31'd0, bus.resp_valid},   32'd1);
    check({tag, "_rdata"}, bus.rdata,                rd);
    check({tag, "_err"},  {31'd0, bus.misalign_err}, {31'd0, err});
    check({tag, "_mreq"}, {31'd0, bus.m_req},        32'd0);
    @(negedge clk);
    check({tag, "_rv1"},  {31'd0, bus.resp_valid},   32'd0);
    check({tag, "_rdy1"}, {31'd0, bus.req_ready},    32'd1);
  endtask

  logic [9:0] a5;
  logic [3:0] be5;

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr      = 10'd0;
    bus.func3     = 3'b000;
    bus.wdata     = 32'h0000_0000;
    bus.m_ack     = 1'b0;
    bus.m_rdata   = 32'h0000_0000;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdy",   {31'd0, bus.req_ready},    32'd1);
    check("rst_rv",    {31'd0, bus.resp_valid},   32'd0);
    check("rst_rdata", bus.rdata,                 32'h0000_0000);
    check("rst_err",   {31'd0, bus.misalign_err}, 32'd0);
    check("rst_mreq",  {31'd0, bus.m_req},        32'd0);
    check("rst_mwe",   {31'd0, bus.m_we},         32'd0);
    check("rst_maddr", {22'd0, bus.m_addr},       32'd0);
    check("rst_mbe",   {28'd0, bus.m_be},         32'd0);
    check("rst_mwd",   bus.m_wdata,               32'h0000_0000);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: LW addr 0, immediate ack, minimum latency
    issue(1'b1, 1'b0, 10'h000, 3'b010, 32'h0000_0000);
    serve("t1", 1'b0, 10'h000, 4'b1111, 32'h0000_0000, 32'h0004_0914, 0);
    resp("t1", 32'h0004_0914, 1'b0);

    // 2: LB / LBU addr 5, byte 5 = 0x80
    issue(1'b1, 1'b0, 10'h005, 3'b000, 32'h0000_0000);
    serve("t2lb", 1'b0, 10'h004, 4'b0010, 32'h0000_0000, 32'h0000_8000, 0);
    resp("t2lb", 32'hFFFF_FF80, 1'b0);
    issue(1'b1, 1'b0, 10'h005, 3'b100, 32'h0000_0000);
    serve("t2lbu", 1'b0, 10'h004, 4'b0010, 32'h0000_0000, 32'h0000_8000, 0);
    resp("t2lbu", 32'h0000_0080, 1'b0);

    // LH / LHU addr 2 (aligned halfword in the upper lanes)
    issue(1'b1, 1'b0, 10'h002, 3'b001, 32'h0000_0000);
    serve("lh", 1'b0, 10'h000, 4'b1100, 32'h0000_0000, 32'h8001_0000, 0);
    resp("lh", 32'hFFFF_8001, 1'b0);
    issue(1'b1, 1'b0, 10'h002, 3'b101, 32'h0000_0000);
    serve("lhu", 1'b0, 10'h000, 4'b1100, 32'h0000_0000, 32'h8001_0000, 0);
    resp("lhu", 32'h0000_8001, 1'b0);

    // SB addr 6 with both mem_read and mem_write set: store wins
    issue(1'b1, 1'b1, 10'h006, 3'b000, 32'h1234_56A5);
    serve("sb", 1'b1, 10'h004, 4'b0100, 32'h56A5_0000, 32'hDEAD_BEEF, 0);
    resp("sb", 32'h0000_0000, 1'b0);

    // 3: SH addr 3 (split store)
    issue(1'b0, 1'b1, 10'h003, 3'b001, 32'h0000_BEEF);
`ifdef MISALIGN_TRAP_EN
    resp("t3trap", 32'h0000_0000, 1'b1);
`else
    serve("t3a0", 1'b1, 10'h000, 4'b1000, 32'hEF00_0000, 32'h0000_0000, 0);
    serve("t3a1", 1'b1, 10'h004, 4'b0001, 32'h0000_00BE, 32'h0000_0000, 0);
    resp("t3", 32'h0000_0000, 1'b0);
`endif

    // 4: LW addr 0x3FE, second word wraps to 0
    issue(1'b1, 1'b0, 10'h3FE, 3'b010, 32'h0000_0000);
`ifdef MISALIGN_TRAP_EN
    resp("t4trap", 32'h0000_0000, 1'b1);
`else
    serve("t4a0", 1'b0, 10'h3FC, 4'b1100, 32'h0000_0000, 32'hAABB_1234, 0);
    serve("t4a1", 1'b0, 10'h000, 4'b0011, 32'h0000_0000, 32'h5678_CCDD, 1);
    resp("t4", 32'hCCDD_AABB, 1'b0);
`endif

    // Illegal func3: load 011 and store 100 complete without a memory access
    issue(1'b1, 1'b0, 10'h000, 3'b011, 32'h0000_0000);
    resp("ill_ld", 32'h0000_0000, 1'b0);
    issue(1'b0, 1'b1, 10'h008, 3'b100, 32'h0000_00FF);
    resp("ill_st", 32'h0000_0000, 1'b0);

    // No read/write flag: nothing accepted; stray ack in IDLE ignored
    bus.m_ack = 1'b1;
    issue(1'b0, 1'b0, 10'h010, 3'b010, 32'h0000_0000);
    check("noop_rdy",  {31'd0, bus.req_ready},  32'd1);
    check("noop_mreq", {31'd0, bus.m_req},      32'd0);
    check("noop_rv",   {31'd0, bus.resp_valid}, 32'd0);
    bus.m_ack = 1'b0;
    @(negedge clk);

    // 6: LW addr 2
    issue(1'b1, 1'b0, 10'h002, 3'b010, 32'h0000_0000);
`ifdef MISALIGN_TRAP_EN
    resp("t6trap", 32'h0000_0000, 1'b1);
`else
    serve("t6a0", 1'b0, 10'h000, 4'b1100, 32'h0000_0000, 32'h1122_3344, 0);
    serve("t6a1", 1'b0, 10'h004, 4'b0011, 32'h0000_0000, 32'h5566_7788, 0);
    resp("t6", 32'h7788_1122, 1'b0);
`endif

    // 5: ack held low 3 cycles, then reset mid-operation
`ifdef MISALIGN_TRAP_EN
    a5  = 10'h000;
    be5 = 4'b1111;
    issue(1'b1, 1'b0, 10'h000, 3'b010, 32'h0000_0000);
`else
    a5  = 10'h3FC;
    be5 = 4'b1100;
    issue(1'b1, 1'b0, 10'h3FE, 3'b010, 32'h0000_0000);
`endif
    check_acc("t5", 1'b0, a5, be5, 32'h0000_0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_acc("t5_stall", 1'b0, a5, be5, 32'h0000_0000);
    end
`ifndef MISALIGN_TRAP_EN
    bus.m_ack   = 1'b1;
    bus.m_rdata = 32'h0101_0101;
    @(posedge clk);
    #1;
    bus.m_ack = 1'b0;
    @(negedge clk);
    check_acc("t5_acc1", 1'b0, 10'h000, 4'b0011, 32'h0000_0000);
`endif
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_rst_mreq", {31'd0, bus.m_req},      32'd0);
    check("t5_rst_rdy",  {31'd0, bus.req_ready},  32'd1);
    check("t5_rst_rv",   {31'd0, bus.resp_valid}, 32'd0);
    bus.m_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_late_rv",   {31'd0, bus.resp_valid}, 32'd0);
      check("t5_late_mreq", {31'd0, bus.m_req},      32'd0);
    end
    bus.m_ack = 1'b0;
    @(negedge clk);

    // Normal operation resumes after the mid-operation reset
    issue(1'b1, 1'b0, 10'h00C, 3'b010, 32'h0000_0000);
    serve("post", 1'b0, 10'h00C, 4'b1111, 32'h0000_0000, 32'hCAFE_F00D, 2);
    resp("post", 32'hCAFE_F00D, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
